gomba_ctrl: RTL and testbench

- Per-frame scheduler and arbiter for a pool of N gomba enemy instances.
- Once per frame_clk rising edge it scans every slot in turn and tests the slot against Mario's bounding box.
- It resolves stomp vs. side-hit contacts, drives each slot's gomba_alive input, and produces the Mario hit/bounce pulses and the stomp score.
- Sits between the Mario movement block and the gomba instances in the top level.

---
 rtl/gomba_ctrl_if.sv | 28 ++
 rtl/gomba_ctrl.sv | 163 ++++++++++++++++
 tb/tb_gomba_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/gomba_ctrl_if.sv
// Bundle between the Mario movement block, gomba_ctrl and the gomba instances.
// master = the controller side, slave = the surrounding top level.
interface gomba_ctrl_if #(
   parameter int N_GOMBA = 4
);
   logic                    frame_clk;
   logic [9:0]              mario_x;
   logic [9:0]              mario_y;
   logic                    mario_falling;
   logic [10*N_GOMBA-1:0]   gomba_x_bus;
   logic [10*N_GOMBA-1:0]   gomba_y_bus;
   logic [N_GOMBA-1:0]      gomba_alive;
   logic [N_GOMBA-1:0]      gomba_respawn;
   logic                    mario_hit;
   logic                    mario_bounce;
   logic [15:0]             score;
   logic                    busy;

   modport master (
      input  frame_clk, mario_x, mario_y, mario_falling, gomba_x_bus, gomba_y_bus,
      output gomba_alive, gomba_respawn, mario_hit, mario_bounce, score, busy
   );

   modport slave (
      output frame_clk, mario_x, mario_y, mario_falling, gomba_x_bus, gomba_y_bus,
      input  gomba_alive, gomba_respawn, mario_hit, mario_bounce, score, busy
   );
endinterface

// File: rtl/gomba_ctrl.sv
// Per-frame stomp/side-hit arbiter over N_GOMBA slots; GOMBA_RESPAWN_EN adds timed respawn.
// Pulses land N_GOMBA+2 Clk after a frame edge; no backpressure, frame edges outside IDLE are dropped.
module gomba_ctrl #(
   parameter int N_GOMBA     = 4,
   parameter int STOMP_SCORE = 100,
   parameter int STOMP_WIN   = 8,
   parameter int INV_FRAMES  = 60
`ifdef GOMBA_RESPAWN_EN
   ,
   parameter int RESPAWN_FRAMES = 180
`endif
) (
   input  logic         Clk,
   input  logic         Reset,
   gomba_ctrl_if.master bus
);
   localparam int IDXW = (N_GOMBA > 1) ? $clog2(N_GOMBA) : 1;
   localparam int INVW = ($clog2(INV_FRAMES + 1) < 1) ? 1 : $clog2(INV_FRAMES + 1);

   typedef enum logic [1:0] {IDLE, SCAN, RESOLVE} state_t;

   state_t               state;
   state_t               state_nxt;
   logic                 frame_d;
   logic                 fe;
   logic [IDXW-1:0]      idx;
   logic                 stomp_seen;
   logic                 side_seen;
   logic [N_GOMBA-1:0]   alive;
   logic [15:0]          score;
   logic [16:0]          score_sum;
   logic [15:0]          score_nxt;
   logic                 hit_q;
   logic                 bounce_q;
   logic                 hit_now;
   logic [INVW-1:0]      inv_cnt;
   logic [N_GOMBA-1:0]   respawn_q;
   logic [10:0]          mx;
   logic [10:0]          my;
   logic [10:0]          gx;
   logic [10:0]          gy;
   logic [31:0]          base;
   logic                 overlap;
   logic                 stomp_hit;
   logic                 test_en;

`ifdef GOMBA_RESPAWN_EN
   localparam int RW = ($clog2(RESPAWN_FRAMES + 1) < 1) ? 1 : $clog2(RESPAWN_FRAMES + 1);
   logic [RW-1:0] resp_cnt [N_GOMBA];
`endif

   assign fe   = bus.frame_clk & ~frame_d;
   assign base = 32'(idx) * 32'd10;
   assign mx   = {1'b0, bus.mario_x};
   assign my   = {1'b0, bus.mario_y};
   assign gx   = {1'b0, bus.gomba_x_bus[base +: 10]};
   assign gy   = {1'b0, bus.gomba_y_bus[base +: 10]};

   // 11-bit sums so boxes near the 1023 edge never wrap into a false overlap
   assign overlap   = (gx < mx + 11'd32) && (mx < gx + 11'd32) &&
                      (gy < my + 11'd32) && (my < gy + 11'd32);
   assign stomp_hit = overlap && bus.mario_falling &&
                      ((my + 11'd32) <= (gy + 11'(STOMP_WIN)));
   assign test_en   = (state == SCAN) && alive[idx] && !stomp_seen;

   assign score_sum = {1'b0, score} + 17'(STOMP_SCORE);
   assign score_nxt = score_sum[16] ? 16'hFFFF : score_sum[15:0];
   assign hit_now   = side_seen & ~stomp_seen & (inv_cnt == '0);

   always_ff @(posedge Clk) begin
      if (!Reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (fe) state_nxt = SCAN;
         SCAN:    if (idx == IDXW'(N_GOMBA - 1)) state_nxt = RESOLVE;
         RESOLVE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state != IDLE);
   end

   always_ff @(posedge Clk) begin
      // Tracked through reset so a level held high across reset is not seen as an edge
      frame_d <= bus.frame_clk;
      if (!Reset) begin
         alive      <= '1;
         score      <= '0;
         hit_q      <= 1'b0;
         bounce_q   <= 1'b0;
         respawn_q  <= '0;
         inv_cnt    <= '0;
         idx        <= '0;
         stomp_seen <= 1'b0;
         side_seen  <= 1'b0;
`ifdef GOMBA_RESPAWN_EN
         for (int i = 0; i < N_GOMBA; i++) resp_cnt[i] <= '0;
`endif
      end else begin
         hit_q     <= 1'b0;
         bounce_q  <= 1'b0;
         respawn_q <= '0;
         case (state)
            IDLE: begin
               if (fe) begin
                  idx        <= '0;
                  stomp_seen <= 1'b0;
                  side_seen  <= 1'b0;
               end
            end
            SCAN: begin
               if (test_en && stomp_hit) begin
                  alive[idx] <= 1'b0;
                  stomp_seen <= 1'b1;
                  score      <= score_nxt;
`ifdef GOMBA_RESPAWN_EN
                  resp_cnt[idx] <= RW'(RESPAWN_FRAMES);
`endif
               end else if (test_en && overlap) begin
                  side_seen <= 1'b1;
               end
               idx <= idx + 1'b1;
            end
            RESOLVE: begin
               bounce_q <= stomp_seen;
               hit_q    <= hit_now;
               if (hit_now)             inv_cnt <= INVW'(INV_FRAMES);
               else if (inv_cnt != '0)  inv_cnt <= inv_cnt - 1'b1;
`ifdef GOMBA_RESPAWN_EN
               for (int i = 0; i < N_GOMBA; i++) begin
                  if (!alive[i] && resp_cnt[i] != '0) begin
                     if (resp_cnt[i] == RW'(1)) begin
                        alive[i]     <= 1'b1;
                        respawn_q[i] <= 1'b1;
                        resp_cnt[i]  <= '0;
                     end else begin
                        resp_cnt[i] <= resp_cnt[i] - 1'b1;
                     end
                  end
               end
`endif
            end
            default: ;
         endcase
      end
   end

   assign bus.gomba_alive  = alive;
   assign bus.score        = score;
   assign bus.mario_hit    = hit_q;
   assign bus.mario_bounce = bounce_q;
`ifdef GOMBA_RESPAWN_EN
   assign bus.gomba_respawn = respawn_q;
`else
   assign bus.gomba_respawn = '0;
`endif
endmodule

// File: tb/tb_gomba_ctrl.sv
// Directed bench for gomba_ctrl: stomp, side hit, immunity, arbitration, window edge, reset abort, saturation.
module tb_gomba_ctrl;
   logic Clk   = 1'b0;
   logic Reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   gomba_ctrl_if #(.N_GOMBA(4)) ifa ();
   gomba_ctrl_if #(.N_GOMBA(4)) ifb ();

   gomba_ctrl #(.N_GOMBA(4)) dut_a (.Clk(Clk), .Reset(Reset), .bus(ifa));
   gomba_ctrl #(.N_GOMBA(4), .STOMP_SCORE(21834)) dut_b (.Clk(Clk), .Reset(Reset), .bus(ifb));

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic set_slot(input int i, input logic [9:0] x, input logic [9:0] y);
      ifa.gomba_x_bus[10*i +: 10] = x;
      ifa.gomba_y_bus[10*i +: 10] = y;
   endtask

   task automatic park_all();
      ifa.gomba_x_bus = {4{10'd900}};
      ifa.gomba_y_bus = '0;
   endtask

   task automatic do_reset();
      Reset = 1'b0;
      repeat (2) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
   endtask

   // One frame edge on ifa, then 12 Clk of observation; lat counts Clk from the fe cycle
   task automatic run_frame(output int bcnt, output int hcnt, output logic [3:0] rsp,
                            output int lat, output logic busy_mid);
      bcnt = 0; hcnt = 0; rsp = '0; lat = -1; busy_mid = 1'b0;
      @(negedge Clk);
      ifa.frame_clk = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge Clk);
         if (c == 1) begin
            ifa.frame_clk = 1'b0;
            busy_mid = ifa.busy;
         end
         if (ifa.mario_bounce) bcnt++;
         if (ifa.mario_hit) hcnt++;
         rsp |= ifa.gomba_respawn;
         if ((ifa.mario_bounce || ifa.mario_hit || (|ifa.gomba_respawn)) && lat < 0) lat = c;
      end
   endtask

   task automatic frame_b();
      @(negedge Clk);
      ifb.frame_clk = 1'b1;
      @(negedge Clk);
      ifb.frame_clk = 1'b0;
      repeat (10) @(negedge Clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int         bc, hc, lt, hsum;
      logic [3:0] rs;
      logic       bm;

      ifa.frame_clk = 1'b0; ifa.mario_x = '0; ifa.mario_y = '0; ifa.mario_falling = 1'b0;
      ifb.frame_clk = 1'b0; ifb.mario_x = '0; ifb.mario_y = '0; ifb.mario_falling = 1'b0;
      park_all();
      ifb.gomba_x_bus = {4{10'd900}};
      ifb.gomba_y_bus = '0;

      do_reset();
      chk("rst_alive",   ifa.gomba_alive, 4'b1111);
      chk("rst_score",   ifa.score, 16'd0);
      chk("rst_busy",    ifa.busy, 1'b0);
      chk("rst_hit",     ifa.mario_hit, 1'b0);
      chk("rst_bounce",  ifa.mario_bounce, 1'b0);
      chk("rst_respawn", ifa.gomba_respawn, 4'b0000);

      // Stomp on slot 2
      set_slot(2, 10'd200, 10'd384);
      ifa.mario_x = 10'd190; ifa.mario_y = 10'd356; ifa.mario_falling = 1'b1;
      run_frame(bc, hc, rs, lt, bm);
      chk("st_bounce_cnt", bc, 1);
      chk("st_hit_cnt",    hc, 0);
      chk("st_latency",    lt, 6);
      chk("st_busy_mid",   bm, 1'b1);
      chk("st_alive",      ifa.gomba_alive, 4'b1011);
      chk("st_score",      ifa.score, 16'd100);
      chk("st_respawn",    rs, 4'b0000);
      chk("st_busy_end",   ifa.busy, 1'b0);

      // Dead slot still overlapping: never tested
      run_frame(bc, hc, rs, lt, bm);
      chk("dead_bounce", bc, 0);
      chk("dead_hit",    hc, 0);
      chk("dead_score",  ifa.score, 16'd100);

      // Side hit, then 60 frames of immunity, then hit again
      set_slot(0, 10'd100, 10'd384);
      ifa.mario_x = 10'd120; ifa.mario_y = 10'd384; ifa.mario_falling = 1'b0;
      run_frame(bc, hc, rs, lt, bm);
      chk("side_hit_cnt", hc, 1);
      chk("side_bounce",  bc, 0);
      chk("side_latency", lt, 6);
      chk("side_alive",   ifa.gomba_alive, 4'b1011);
      hsum = 0;
      for (int f = 0; f < 60; f++) begin
         run_frame(bc, hc, rs, lt, bm);
         hsum += hc;
      end
      chk("inv_no_hit", hsum, 0);
      run_frame(bc, hc, rs, lt, bm);
      chk("inv_rehit", hc, 1);

      // Two overlapping slots: lowest index wins, one stomp per frame
      do_reset();
      park_all();
      set_slot(0, 10'd300, 10'd384);
      set_slot(1, 10'd300, 10'd384);
      ifa.mario_x = 10'd300; ifa.mario_y = 10'd360; ifa.mario_falling = 1'b1;
      run_frame(bc, hc, rs, lt, bm);
      chk("arb_alive",  ifa.gomba_alive, 4'b1110);
      chk("arb_bounce", bc, 1);
      chk("arb_hit",    hc, 0);
      chk("arb_score",  ifa.score, 16'd100);
      run_frame(bc, hc, rs, lt, bm);
      chk("arb2_alive", ifa.gomba_alive, 4'b1100);
      chk("arb2_score", ifa.score, 16'd200);

      // Bottom edge one pixel past the stomp window: side hit instead
      set_slot(2, 10'd300, 10'd384);
      ifa.mario_y = 10'd361;
      run_frame(bc, hc, rs, lt, bm);
      chk("win_hit",    hc, 1);
      chk("win_bounce", bc, 0);
      chk("win_alive",  ifa.gomba_alive, 4'b1100);
      chk("win_score",  ifa.score, 16'd200);

`ifdef GOMBA_RESPAWN_EN
      do_reset();
      park_all();
      set_slot(3, 10'd600, 10'd384);
      ifa.mario_x = 10'd600; ifa.mario_y = 10'd360; ifa.mario_falling = 1'b1;
      run_frame(bc, hc, rs, lt, bm);
      chk("rsp_kill_alive", ifa.gomba_alive, 4'b0111);
      ifa.mario_x = 10'd0; ifa.mario_y = 10'd0; ifa.mario_falling = 1'b0;
      hsum = 0;
      for (int f = 2; f < 180; f++) begin
         run_frame(bc, hc, rs, lt, bm);
         hsum += int'(rs);
      end
      chk("rsp_early",      hsum, 0);
      chk("rsp_still_dead", ifa.gomba_alive, 4'b0111);
      run_frame(bc, hc, rs, lt, bm);
      chk("rsp_pulse",      rs, 4'b1000);
      chk("rsp_latency",    lt, 6);
      chk("rsp_alive",      ifa.gomba_alive, 4'b1111);
`endif

      // Reset asserted mid-scan aborts the frame
      do_reset();
      park_all();
      set_slot(0, 10'd300, 10'd384);
      ifa.mario_x = 10'd300; ifa.mario_y = 10'd360; ifa.mario_falling = 1'b1;
      @(negedge Clk); ifa.frame_clk = 1'b1;
      @(negedge Clk); ifa.frame_clk = 1'b0;
      chk("abort_busy_pre", ifa.busy, 1'b1);
      @(negedge Clk); Reset = 1'b0;
      @(negedge Clk);
      chk("abort_busy",  ifa.busy, 1'b0);
      chk("abort_alive", ifa.gomba_alive, 4'b1111);
      chk("abort_score", ifa.score, 16'd0);
      Reset = 1'b1;
      bc = 0; hc = 0;
      repeat (8) begin
         @(negedge Clk);
         if (ifa.mario_bounce) bc++;
         if (ifa.mario_hit) hc++;
      end
      chk("abort_no_bounce", bc, 0);
      chk("abort_no_hit",    hc, 0);

      // Score saturation on the large-increment instance
      ifb.gomba_x_bus = {4{10'd500}};
      ifb.gomba_y_bus = {4{10'd384}};
      ifb.mario_x = 10'd500; ifb.mario_y = 10'd360; ifb.mario_falling = 1'b1;
      repeat (3) frame_b();
      chk("sat_pre_score", ifb.score, 16'd65502);
      chk("sat_pre_alive", ifb.gomba_alive, 4'b1000);
      frame_b();
      chk("sat_score", ifb.score, 16'hFFFF);
      chk("sat_alive", ifb.gomba_alive, 4'b0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
